// File: rtl/count_seg_display.sv
`default_nettype none
// ============================================================================
// Module      : count_seg_display
// Description : Display stage for the selectable 4-bit counter. It drives a
//               4-digit, common-anode, multiplexed seven-segment display:
//               digits 1..0 show the count in decimal (0..15), digit 2 is
//               blank, and digit 3 shows the mode letter (U/d/E/o). The
//               digit-0 decimal point flashes for FLASH_FRAMES scan frames
//               after every count change.
//
//               The count and mode are snapshotted once per scan frame, so
//               a frame never shows a torn value.
//
// Parameters  : REFRESH_DIV  - clk cycles per digit slot (2 .. 2^20)
//               FLASH_FRAMES - frames the DP stays lit after a change (1..255)
//
// Ports       : clk    in   system clock, rising edge
//               Clear  in   asynchronous active-low reset
//               count  in   [3:0] counter value
//               sel    in   [1:0] mode: 00 up, 01 down, 10 even, 11 odd
//               seg    out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//               dp     out  decimal point, active-low
//               an     out  [3:0] digit enables, active-low, an[0] rightmost
//
// Revision    : 1.0 - initial release
// ============================================================================
module count_seg_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter int FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       Clear,
    input  logic [3:0] count,
    input  logic [1:0] sel,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter guard
    // ------------------------------------------------------------------------
    generate
        if ((REFRESH_DIV < 2) || (REFRESH_DIV > (1 << 20))) begin : g_bad_refresh_div
            $error("count_seg_display: REFRESH_DIV out of range 2..2^20");
        end
        if ((FLASH_FRAMES < 1) || (FLASH_FRAMES > 255)) begin : g_bad_flash_frames
            $error("count_seg_display: FLASH_FRAMES out of range 1..255");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              C_P_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [C_P_W-1:0] C_P_LAST = C_P_W'(REFRESH_DIV - 1);
    localparam logic [7:0]      C_FL_LOAD = 8'(FLASH_FRAMES);

    // Segment patterns, {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] C_SEG_0     = 7'b1000000;
    localparam logic [6:0] C_SEG_1     = 7'b1111001;
    localparam logic [6:0] C_SEG_2     = 7'b0100100;
    localparam logic [6:0] C_SEG_3     = 7'b0110000;
    localparam logic [6:0] C_SEG_4     = 7'b0011001;
    localparam logic [6:0] C_SEG_5     = 7'b0010010;
    localparam logic [6:0] C_SEG_6     = 7'b0000010;
    localparam logic [6:0] C_SEG_7     = 7'b1111000;
    localparam logic [6:0] C_SEG_8     = 7'b0000000;
    localparam logic [6:0] C_SEG_9     = 7'b0010000;
    localparam logic [6:0] C_SEG_U     = 7'b1000001;
    localparam logic [6:0] C_SEG_D     = 7'b0100001;
    localparam logic [6:0] C_SEG_E     = 7'b0000110;
    localparam logic [6:0] C_SEG_O     = 7'b0100011;
    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;

    localparam logic [1:0] C_IDX_ONES   = 2'd0;
    localparam logic [1:0] C_IDX_TENS   = 2'd1;
    localparam logic [1:0] C_IDX_BLANK  = 2'd2;
    localparam logic [1:0] C_IDX_LETTER = 2'd3;

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = C_SEG_0;
            4'd1:    s = C_SEG_1;
            4'd2:    s = C_SEG_2;
            4'd3:    s = C_SEG_3;
            4'd4:    s = C_SEG_4;
            4'd5:    s = C_SEG_5;
            4'd6:    s = C_SEG_6;
            4'd7:    s = C_SEG_7;
            4'd8:    s = C_SEG_8;
            4'd9:    s = C_SEG_9;
            default: s = C_SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] mode_to_seg(input logic [1:0] m);
        logic [6:0] s;
        case (m)
            2'b00:   s = C_SEG_U;
            2'b01:   s = C_SEG_D;
            2'b10:   s = C_SEG_E;
            default: s = C_SEG_O;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [C_P_W-1:0] p_q,        p_d;
    logic [1:0]       idx_q,      idx_d;
    logic [3:0]       snap_cnt_q, snap_cnt_d;
    logic [1:0]       snap_sel_q, snap_sel_d;
    logic [7:0]       fl_q,       fl_d;
    logic [6:0]       seg_q,      seg_d;
    logic             dp_q,       dp_d;
    logic [3:0]       an_q,       an_d;

    logic             w_tick;
    logic             w_frame_wrap;
    logic [3:0]       w_ones;

    assign w_tick       = (p_q == C_P_LAST);
    assign w_frame_wrap = w_tick && (idx_q == C_IDX_LETTER);

    // Count is 0..15, so "mod 10" is a single conditional subtract.
    assign w_ones = (snap_cnt_q >= 4'd10) ? (snap_cnt_q - 4'd10) : snap_cnt_q;

    // ------------------------------------------------------------------------
    // Scan timing and per-frame snapshot
    // ------------------------------------------------------------------------
    always_comb begin
        p_d        = p_q + C_P_W'(1);
        idx_d      = idx_q;
        snap_cnt_d = snap_cnt_q;
        snap_sel_d = snap_sel_q;
        fl_d       = fl_q;

        if (w_tick) begin
            p_d   = '0;
            idx_d = idx_q + 2'd1;
        end

        if (w_frame_wrap) begin
            snap_cnt_d = count;
            snap_sel_d = sel;
            // A fresh count change always reloads, even while still flashing;
            // the decrement only applies to frames with an unchanged count.
            if (count != snap_cnt_q) begin
                fl_d = C_FL_LOAD;
            end else if (fl_q != 8'd0) begin
                fl_d = fl_q - 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output decode (registered one cycle behind idx so the pins never see
    // the combinational decode settling)
    // ------------------------------------------------------------------------
    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = C_SEG_BLANK;
        dp_d  = 1'b1;

        case (idx_q)
            C_IDX_ONES: begin
                seg_d = digit_to_seg(w_ones);
                dp_d  = (fl_q == 8'd0);
            end
            C_IDX_TENS: begin
                seg_d = (snap_cnt_q >= 4'd10) ? C_SEG_1 : C_SEG_BLANK;
            end
            C_IDX_BLANK: begin
                seg_d = C_SEG_BLANK;
            end
            default: begin
                seg_d = mode_to_seg(snap_sel_q);
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            p_q        <= '0;
            idx_q      <= 2'd0;
            snap_cnt_q <= 4'd0;
            snap_sel_q <= 2'b00;
            fl_q       <= 8'd0;
            seg_q      <= C_SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= 4'b1111;
        end else begin
            p_q        <= p_d;
            idx_q      <= idx_d;
            snap_cnt_q <= snap_cnt_d;
            snap_sel_q <= snap_sel_d;
            fl_q       <= fl_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_count_seg_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_seg_display
// Description : Self-checking bench for count_seg_display with
//               REFRESH_DIV=4, FLASH_FRAMES=2. A cycle-arithmetic model of
//               the display is compared against the outputs on every falling
//               edge; directed scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_seg_display;

    localparam int R = 4;
    localparam int F = 2;

    logic       clk;
    logic       Clear;
    logic [3:0] count;
    logic [1:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    count_seg_display #(
        .REFRESH_DIV  (R),
        .FLASH_FRAMES (F)
    ) dut (
        .clk   (clk),
        .Clear (Clear),
        .count (count),
        .sel   (sel),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference tables
    // ------------------------------------------------------------------------
    logic [6:0] dig_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                  7'b0110000, 7'b0011001, 7'b0010010,
                                  7'b0000010, 7'b1111000, 7'b0000000,
                                  7'b0010000};
    logic [6:0] let_tab [0:3] = '{7'b1000001, 7'b0100001, 7'b0000110,
                                  7'b0100011};

    task automatic chk(input string nm, input logic [11:0] act,
                       input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b at %0t", nm, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: position in the scan is pure arithmetic on cycles since reset.
    // exp_* holds what the outputs must be after the most recent edge.
    // ------------------------------------------------------------------------
    int         m_cyc;
    int         m_snap;
    int         m_sel;
    int         m_fl;
    int         m_slot;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    always @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            m_cyc   = 0;
            m_snap  = 0;
            m_sel   = 0;
            m_fl    = 0;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
        end else begin
            m_slot = (m_cyc / R) % 4;
            exp_an = ~(4'b0001 << m_slot);
            case (m_slot)
                0:       exp_seg = dig_tab[m_snap % 10];
                1:       exp_seg = (m_snap >= 10) ? dig_tab[1] : 7'b1111111;
                2:       exp_seg = 7'b1111111;
                default: exp_seg = let_tab[m_sel];
            endcase
            exp_dp = !((m_slot == 0) && (m_fl > 0));
            if ((m_cyc % (4 * R)) == (4 * R - 1)) begin
                if (int'(count) != m_snap) m_fl = F;
                else if (m_fl > 0)         m_fl = m_fl - 1;
                m_snap = int'(count);
                m_sel  = int'(sel);
            end
            m_cyc++;
        end
    end

    // Single compare process against the model
    always @(negedge clk) begin
        if (!Clear) chk("model_reset", {an, seg, dp}, 12'hFFF);
        else        chk("model", {an, seg, dp}, {exp_an, exp_seg, exp_dp});
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic wait_an(input logic [3:0] target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((an !== target) && (n < 200));
        if (an !== target) begin
            checks++;
            errors++;
            $display("FAIL wait_an: an=%b never reached %b", an, target);
        end
    endtask

    // Leaves the bench on the first falling edge of the next frame's digit-0.
    task automatic sync_frame();
        wait_an(4'b0111);
        wait_an(4'b1110);
    endtask

    logic [3:0] dec_an  [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] dec_seg [0:3] = '{7'b0110000, 7'b1111001, 7'b1111111,
                                  7'b0100001};

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        Clear = 1'b0;
        count = 4'd9;
        sel   = 2'b00;

        // Reset held
        repeat (5) begin
            @(negedge clk);
            chk("reset_hold", {an, seg, dp}, 12'hFFF);
        end
        Clear = 1'b1;
        @(negedge clk);
        chk("release", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});

        // Decimal and letter decode: 13 in mode "down", three frames
        count = 4'd13;
        sel   = 2'b01;
        sync_frame();
        for (int i = 0; i < 48; i++) begin
            if (i > 0) @(negedge clk);
            chk("decode", {1'b0, an, seg},
                {1'b0, dec_an[(i / 4) % 4], dec_seg[(i / 4) % 4]});
        end

        // No tearing: 5 -> 7 mid idx1 slot
        count = 4'd5;
        sync_frame();
        chk("tear_pre", {5'd0, seg}, {5'd0, 7'b0010010});
        repeat (5) @(negedge clk);
        count = 4'd7;
        wait_an(4'b0111);
        chk("tear_letter", {5'd0, seg}, {5'd0, 7'b0100001});
        wait_an(4'b1110);
        chk("tear_post", {5'd0, seg}, {5'd0, 7'b1111000});

        // Flash: let the 5->7 flash expire, then 7 -> 8
        repeat (3) sync_frame();
        count = 4'd8;
        for (int f = 0; f < 3; f++) begin
            sync_frame();
            if (f == 0) chk("flash_seg", {5'd0, seg}, {5'd0, 7'b0000000});
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clk);
                chk("flash_dp", {11'd0, dp}, {11'd0, (f >= 2)});
            end
        end

        // Sel-only change: no flash, letter o
        sel = 2'b00;
        sync_frame();
        sel = 2'b11;
        sync_frame();
        chk("sel_no_flash", {11'd0, dp}, 12'd1);
        wait_an(4'b0111);
        chk("letter_o", {5'd0, seg}, {5'd0, 7'b0100011});

        // Asynchronous reset in the middle of the idx2 slot
        wait_an(4'b1011);
        @(posedge clk);
        #2 Clear = 1'b0;
        #1 chk("async_reset", {an, seg, dp}, 12'hFFF);
        @(negedge clk);
        Clear = 1'b1;
        @(negedge clk);
        chk("restart", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});

        // Wrap-around 15 -> 0
        count = 4'd15;
        repeat (3) sync_frame();
        wait_an(4'b1101);
        chk("wrap_pre_tens", {5'd0, seg}, {5'd0, 7'b1111001});
        count = 4'd0;
        sync_frame();
        chk("wrap_ones", {4'd0, seg, dp}, {4'd0, 7'b1000000, 1'b0});
        wait_an(4'b1101);
        chk("wrap_tens_blank", {5'd0, seg}, {5'd0, 7'b1111111});
        sync_frame();
        chk("wrap_dp2", {11'd0, dp}, 12'd0);
        sync_frame();
        chk("wrap_dp_off", {11'd0, dp}, 12'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
